// File: rtl/iob_cache_line_fill_if.sv
// Bundle of the miss, back-end read, data-memory and tag-memory ports used by the line-fill engine.
interface iob_cache_line_fill_if #(
  parameter int unsigned N_WAYS        = 4,
  parameter int unsigned NLINES_W      = 7,
  parameter int unsigned TAG_W         = 21,
  parameter int unsigned WORD_OFFSET_W = 2,
  parameter int unsigned DATA_W        = 32
);
  localparam int unsigned BE_ADDR_W = TAG_W + NLINES_W + WORD_OFFSET_W + 2;

  logic                              miss_i;
  logic [TAG_W-1:0]                  miss_tag_i;
  logic [NLINES_W-1:0]               miss_line_i;
  logic                              ready_o;
  logic [N_WAYS-1:0]                 way_select_i;
  logic                              be_valid_o;
  logic [BE_ADDR_W-1:0]              be_addr_o;
  logic                              be_ready_i;
  logic                              be_rvalid_i;
  logic [DATA_W-1:0]                 be_rdata_i;
  logic [N_WAYS-1:0]                 dmem_we_o;
  logic [NLINES_W+WORD_OFFSET_W-1:0] dmem_addr_o;
  logic [DATA_W-1:0]                 dmem_wdata_o;
  logic [N_WAYS-1:0]                 tag_we_o;
  logic [TAG_W-1:0]                  tag_wdata_o;
  logic [NLINES_W-1:0]               tag_line_o;
  logic                              done_o;

  // Fill engine side
  modport master (
    input  miss_i, miss_tag_i, miss_line_i, way_select_i,
           be_ready_i, be_rvalid_i, be_rdata_i,
    output ready_o, be_valid_o, be_addr_o,
           dmem_we_o, dmem_addr_o, dmem_wdata_o,
           tag_we_o, tag_wdata_o, tag_line_o, done_o
  );

  // Requester / back-end / memory side
  modport slave (
    output miss_i, miss_tag_i, miss_line_i, way_select_i,
           be_ready_i, be_rvalid_i, be_rdata_i,
    input  ready_o, be_valid_o, be_addr_o,
           dmem_we_o, dmem_addr_o, dmem_wdata_o,
           tag_we_o, tag_wdata_o, tag_line_o, done_o
  );
endinterface

// File: rtl/iob_cache_line_fill.sv
// Cache line-fill engine: fetches one line word-by-word from the back-end into the victim way,
// then writes the tag and pulses done.
module iob_cache_line_fill #(
  parameter int unsigned N_WAYS        = 4,
  parameter int unsigned NWAYS_W       = $clog2(N_WAYS),
  parameter int unsigned NLINES_W      = 7,
  parameter int unsigned TAG_W         = 21,
  parameter int unsigned WORD_OFFSET_W = 2,
  parameter int unsigned DATA_W        = 32
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  iob_cache_line_fill_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] TAG  = 2'd3;

  localparam logic [WORD_OFFSET_W-1:0] LAST_WORD = '1;

  if (N_WAYS > (2 ** NWAYS_W)) begin : g_bad_nways_w
    $error("NWAYS_W too narrow for N_WAYS");
  end

  logic [1:0]               state_q, state_d;
  logic [TAG_W-1:0]         tag_q, tag_d;
  logic [NLINES_W-1:0]      line_q, line_d;
  logic [N_WAYS-1:0]        way_q, way_d;
  logic [WORD_OFFSET_W-1:0] cnt_q, cnt_d;
  logic                     way_onehot;

  // A malformed victim selection falls back to way 0 so exactly one way is written.
  assign way_onehot = (bus.way_select_i != '0) &&
                      ((bus.way_select_i & (bus.way_select_i - N_WAYS'(1))) == '0);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      tag_q   <= '0;
      line_q  <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    tag_d            = tag_q;
    line_d           = line_q;
    way_d            = way_q;
    cnt_d            = cnt_q;
    bus.ready_o      = 1'b0;
    bus.be_valid_o   = 1'b0;
    bus.be_addr_o    = '0;
    bus.dmem_we_o    = '0;
    bus.dmem_addr_o  = '0;
    bus.dmem_wdata_o = '0;
    bus.tag_we_o     = '0;
    bus.tag_wdata_o  = '0;
    bus.tag_line_o   = '0;
    bus.done_o       = 1'b0;

    case (state_q)
      IDLE: begin
        bus.ready_o = 1'b1;
        if (bus.miss_i) begin
          tag_d   = bus.miss_tag_i;
          line_d  = bus.miss_line_i;
          way_d   = way_onehot ? bus.way_select_i : N_WAYS'(1);
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        bus.be_valid_o = 1'b1;
        bus.be_addr_o  = {tag_q, line_q, cnt_q, 2'b00};
        if (bus.be_ready_i) state_d = WAIT;
      end
      WAIT: begin
        // Data is written in the same cycle it returns; the counter wraps to 0 after the last word.
        if (bus.be_rvalid_i) begin
          bus.dmem_we_o    = way_q;
          bus.dmem_addr_o  = {line_q, cnt_q};
          bus.dmem_wdata_o = bus.be_rdata_i;
          cnt_d            = cnt_q + WORD_OFFSET_W'(1);
          state_d          = (cnt_q == LAST_WORD) ? TAG : REQ;
        end
      end
      TAG: begin
        bus.tag_we_o    = way_q;
        bus.tag_wdata_o = tag_q;
        bus.tag_line_o  = line_q;
        bus.done_o      = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_iob_cache_line_fill.sv
// Directed bench for iob_cache_line_fill: table of fills plus hand-written spurious-input and reset sequences.
module tb_iob_cache_line_fill;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  iob_cache_line_fill_if bus ();

  iob_cache_line_fill dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .bus      (bus)
  );

  typedef struct {
    logic [20:0] tag;
    logic [6:0]  line;
    logic [3:0]  way;
    logic [3:0]  exp_way;
    int          stall_word;
    int          stall_n;
    bit          noisy;
  } fill_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.miss_i       = 1'b0;
    bus.miss_tag_i   = '0;
    bus.miss_line_i  = '0;
    bus.way_select_i = '0;
    bus.be_ready_i   = 1'b0;
    bus.be_rvalid_i  = 1'b0;
    bus.be_rdata_i   = '0;
  endtask

  function automatic logic [31:0] word_data(input logic [20:0] tag, input int w);
    return 32'hC0DE_0000 ^ {11'd0, tag} ^ (32'(w) << 24);
  endfunction

  // One complete fill with an ideal back-end (ready immediate, rvalid one cycle later),
  // optional stall on one word, optional spurious rvalid in REQ and miss held through the fill.
  task automatic do_fill(input fill_vec_t v);
    int cyc;
    logic [31:0] exp_addr;
    cyc = 0;
    @(negedge clk);
    bus.miss_i = 1'b1; bus.miss_tag_i = v.tag; bus.miss_line_i = v.line; bus.way_select_i = v.way;
    #1 check("ready_at_accept", 64'(bus.ready_o), 64'd1);
    for (int w = 0; w < 4; w++) begin
      exp_addr = (32'(v.tag) << 11) | (32'(v.line) << 4) | (32'(w) << 2);
      if (w == v.stall_word) begin
        for (int s = 0; s < v.stall_n; s++) begin
          @(negedge clk); cyc++;
          if (!v.noisy) bus.miss_i = 1'b0;
          bus.be_ready_i = 1'b0; bus.be_rvalid_i = 1'b0;
          #1 check("stall_valid", 64'(bus.be_valid_o), 64'd1);
          check("stall_addr", 64'(bus.be_addr_o), 64'(exp_addr));
        end
      end
      @(negedge clk); cyc++;
      if (!v.noisy) bus.miss_i = 1'b0;
      bus.be_ready_i = 1'b1;
      bus.be_rvalid_i = v.noisy;
      bus.be_rdata_i = 32'hDEAD_BEEF;
      #1 check("req_valid", 64'(bus.be_valid_o), 64'd1);
      check("req_addr", 64'(bus.be_addr_o), 64'(exp_addr));
      check("req_ready_low", 64'(bus.ready_o), 64'd0);
      if (v.noisy) check("req_spurious_we", 64'(bus.dmem_we_o), 64'd0);
      @(negedge clk); cyc++;
      bus.be_ready_i = 1'b0; bus.be_rvalid_i = 1'b1; bus.be_rdata_i = word_data(v.tag, w);
      #1 check("wait_valid_low", 64'(bus.be_valid_o), 64'd0);
      check("dmem_we", 64'(bus.dmem_we_o), 64'(v.exp_way));
      check("dmem_addr", 64'(bus.dmem_addr_o), 64'(v.line) * 64'd4 + 64'(w));
      check("dmem_wdata", 64'(bus.dmem_wdata_o), 64'(word_data(v.tag, w)));
      check("no_early_tag_we", 64'(bus.tag_we_o), 64'd0);
    end
    @(negedge clk); cyc++;
    bus.miss_i = 1'b0; bus.be_rvalid_i = 1'b0;
    #1 check("done_cycle", 64'(cyc), 64'(9 + v.stall_n));
    check("done", 64'(bus.done_o), 64'd1);
    check("tag_we", 64'(bus.tag_we_o), 64'(v.exp_way));
    check("tag_wdata", 64'(bus.tag_wdata_o), 64'(v.tag));
    check("tag_line", 64'(bus.tag_line_o), 64'(v.line));
    check("tag_cycle_we", 64'(bus.dmem_we_o), 64'd0);
    @(negedge clk); cyc++;
    #1 check("ready_cycle", 64'(cyc), 64'(10 + v.stall_n));
    check("ready_after", 64'(bus.ready_o), 64'd1);
    check("done_pulse", 64'(bus.done_o), 64'd0);
    check("tag_we_pulse", 64'(bus.tag_we_o), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.ready_o), 64'd1);
    check({tag, "_be_valid"}, 64'(bus.be_valid_o), 64'd0);
    check({tag, "_be_addr"}, 64'(bus.be_addr_o), 64'd0);
    check({tag, "_dmem_we"}, 64'(bus.dmem_we_o), 64'd0);
    check({tag, "_tag_we"}, 64'(bus.tag_we_o), 64'd0);
    check({tag, "_done"}, 64'(bus.done_o), 64'd0);
  endtask

  initial begin
    fill_vec_t vecs[6];
    fill_vec_t v;
    vecs[0] = '{21'h1A,     7'd5,   4'b0100, 4'b0100, -1, 0, 1'b0};
    vecs[1] = '{21'h1FFFFF, 7'd127, 4'b1000, 4'b1000, -1, 0, 1'b0};
    vecs[2] = '{21'h0,      7'd0,   4'b0000, 4'b0001, -1, 0, 1'b0};
    vecs[3] = '{21'h12345,  7'd3,   4'b0110, 4'b0001, -1, 0, 1'b0};
    vecs[4] = '{21'h1A,     7'd5,   4'b0010, 4'b0010,  2, 3, 1'b0};
    vecs[5] = '{21'h0ABCD,  7'd64,  4'b0001, 4'b0001,  0, 1, 1'b0};

    idle_inputs();
    #12 check_reset_outputs("in_reset");
    @(negedge clk); arst_n = 1'b1;
    #1 check_reset_outputs("after_reset");

    for (int i = 0; i < 6; i++) do_fill(vecs[i]);

    // Spurious rvalid while idle: no write, no fill.
    @(negedge clk);
    bus.be_rvalid_i = 1'b1; bus.be_rdata_i = 32'h1234_5678;
    #1 check("idle_spurious_we", 64'(bus.dmem_we_o), 64'd0);
    @(negedge clk);
    bus.be_rvalid_i = 1'b0;
    #1 check("idle_stays_idle", 64'(bus.ready_o), 64'd1);

    // Spurious rvalid in REQ and miss held through the fill: exactly one fill and one done.
    v = '{21'h0F0F0, 7'd9, 4'b1000, 4'b1000, -1, 0, 1'b1};
    do_fill(v);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 check("quiet_done", 64'(bus.done_o), 64'd0);
      check("quiet_be_valid", 64'(bus.be_valid_o), 64'd0);
      check("quiet_ready", 64'(bus.ready_o), 64'd1);
    end

    // Reset after word 1 written: fill abandoned, no tag write.
    @(negedge clk);
    bus.miss_i = 1'b1; bus.miss_tag_i = 21'h1A; bus.miss_line_i = 7'd5; bus.way_select_i = 4'b0100;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      bus.miss_i = 1'b0; bus.be_ready_i = 1'b1; bus.be_rvalid_i = 1'b0;
      @(negedge clk);
      bus.be_ready_i = 1'b0; bus.be_rvalid_i = 1'b1; bus.be_rdata_i = word_data(21'h1A, w);
      #1 check("rst_seq_we", 64'(bus.dmem_we_o), 64'b0100);
    end
    @(negedge clk);
    bus.be_rvalid_i = 1'b0;
    arst_n = 1'b0;
    #1 check_reset_outputs("mid_fill_reset");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1 check("rst_hold_tag_we", 64'(bus.tag_we_o), 64'd0);
    end
    arst_n = 1'b1;
    @(negedge clk);
    #1 check_reset_outputs("post_release");
    do_fill(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/iob_cache_line_fill.md
IOB_CACHE_LINE_FILL -- requirements
Module: iob_cache_line_fill

Interface
REQ-001 SHALL have parameters: N_WAYS, default 4, cache associativity; NWAYS_W, default $clog2(N_WAYS), way index width; NLINES_W, default 7, line address width; TAG_W, default 21, tag width; WORD_OFFSET_W, default 2, words per line = 2**WORD_OFFSET_W; DATA_W, default 32, word width.
REQ-002 SHALL have ports: clk_i  in  1  clock; arst_n_i  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: miss_i  in  1  fill request; miss_tag_i  in  TAG_W  missing tag; miss_line_i  in  NLINES_W  missing line index; ready_o  out  1  idle, accepts miss_i.
REQ-004 SHALL have ports: way_select_i  in  N_WAYS  victim way from the replacement stage, one-hot.
REQ-005 SHALL have ports: be_valid_o  out  1  back-end word request; be_addr_o  out  TAG_W+NLINES_W+WORD_OFFSET_W+2  byte address; be_ready_i  in  1  request accepted; be_rvalid_i  in  1  read data valid; be_rdata_i  in  DATA_W  read data.
REQ-006 SHALL have ports: dmem_we_o  out  N_WAYS  data-memory way write enables; dmem_addr_o  out  NLINES_W+WORD_OFFSET_W  {line, word}; dmem_wdata_o  out  DATA_W  write data.
REQ-007 SHALL have ports: tag_we_o  out  N_WAYS  tag/valid way write enables; tag_wdata_o  out  TAG_W  tag; tag_line_o  out  NLINES_W  line; done_o  out  1  fill-complete pulse.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT, TAG; ready_o = 1 only in IDLE.
REQ-009 In IDLE with miss_i = 1 SHALL register miss_tag_i, miss_line_i, way_select_i, clear word counter to 0, go to REQ next cycle.
REQ-010 If registered way_select_i is zero or not one-hot SHALL substitute way 0 (one-hot 1) for all writes.
REQ-011 In REQ SHALL assert be_valid_o with be_addr_o = {tag_q, line_q, word_cnt, 2'b00}; be_valid_o and be_addr_o SHALL hold stable until be_ready_i = 1, then go to WAIT.
REQ-012 In WAIT, on be_rvalid_i = 1, SHALL drive dmem_we_o = way_q, dmem_addr_o = {line_q, word_cnt}, dmem_wdata_o = be_rdata_i in that same cycle (combinational from be_rvalid_i); dmem_we_o = 0 otherwise.
REQ-013 On that write, if word_cnt = 2**WORD_OFFSET_W-1 SHALL go to TAG, else increment word_cnt and return to REQ.
REQ-014 word_cnt SHALL be WORD_OFFSET_W bits, wrapping to 0 after the last word; exactly 2**WORD_OFFSET_W dmem writes per fill.
REQ-015 be_rvalid_i outside WAIT SHALL be ignored; be_ready_i outside REQ SHALL be ignored; one request outstanding maximum.
REQ-016 TAG SHALL last one cycle: tag_we_o = way_q, tag_wdata_o = tag_q, tag_line_o = line_q, done_o = 1; next state IDLE.
REQ-017 miss_i while not in IDLE SHALL be ignored; requester must hold miss_i until ready_o.
REQ-018 Latency with be_ready_i immediate and be_rvalid_i one cycle later: miss_i sampled cycle 0, first be_valid_o cycle 1, done_o cycle 2*2**WORD_OFFSET_W+1 (9 for defaults), ready_o cycle 10.
REQ-019 done_o and tag_we_o SHALL be single-cycle pulses; no tag write before all words are written.

Reset
REQ-020 arst_n_i = 0 SHALL asynchronously force IDLE, word_cnt = 0, registered tag/line/way = 0; outputs: ready_o = 1, all others 0.
REQ-021 Reset mid-fill SHALL abandon the fill without tag_we_o; already-written words stay, line remains invalid; first cycle after release is IDLE.

Verification
REQ-022 Defaults, miss tag 0x1A, line 5, way 0b0100, back-end ready immediate, rvalid +1 -> be_addr_o 0x1A<<11|5<<4|0x0,0x4,0x8,0xC; dmem_we_o 0b0100 at addrs 20..23; tag_we_o 0b0100 and done_o at cycle 9.
REQ-023 be_ready_i held low 3 cycles on word 2 -> be_valid_o/be_addr_o stable all 3 cycles; fill completes 3 cycles late, data order unchanged.
REQ-024 way_select_i = 0 at accept -> all dmem_we_o and tag_we_o = 0b0001.
REQ-025 Spurious be_rvalid_i in IDLE and in REQ, second miss_i during fill -> no dmem writes, no new fill; only one done_o.
REQ-026 arst_n_i low after word 1 written -> outputs reset immediately, tag_we_o never asserted, ready_o = 1; subsequent miss performs full fill from word 0.
